nbcac_tx_stream_encoder: RTL and testbench

Transmit-side stage of the 12-bit NBCAC link: accepts raw 12-bit data words through a valid/ready handshake, buffers them in a small FIFO, and encodes each word with `nbcac_12di_encoder_core`. It drives the registered 17-bit crosstalk-avoidance codeword onto the on-chip bus, which feeds `NBCAC_decoder_17` at the far end. The bus holds its last codeword while idle, so no extra transitions are introduced. An optional loopback checker decodes every launched codeword and flags mismatches.

---
 rtl/nbcac_tx_stream_encoder.sv | 210 +++++++++++++++++++++
 tb/tb_nbcac_tx_stream_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nbcac_tx_stream_encoder.sv
// nbcac_tx_stream_encoder: buffers 12-bit words and launches registered 17-bit NBCAC codewords onto the bus.
// Latency: word accepted at edge N is on codeout after edge N+1; one word per cycle sustained.
// Backpressure: din_ready = FIFO not full (registered count only); codeout/code_valid hold while code_ready is low.
//
// Ports: clock, rst_n (async, active-low); din/din_valid/din_ready input handshake;
//        codeout[17:1]/code_valid/code_ready output handshake; words_sent completed-handshake counter;
//        chk_err sticky loopback mismatch flag.
// Optional loopback checker: define NBCAC_LOOPBACK_CHECK_EN to build the decoder and drive chk_err.
//
// Code: the 17-bit codewords are the forbidden-pattern-free words (no 010 / 101 anywhere), and data value d
// maps to the d-th such word in ascending order, so the all-zero word encodes 0.

package nbcac_fpf_pkg;
  // Number of legal tails of length k when the next bit may take either value (1,2,3,5,8,...).
  function automatic logic [12:0] fpf_free(input int k);
    int a, b, t;
    a = 1;
    b = 2;
    for (int i = 1; i < k; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    fpf_free = (k == 0) ? 13'(a) : 13'(b);
  endfunction

  // Legal tails of length k right after a bit that differs from its predecessor (next bit must repeat).
  function automatic logic [12:0] fpf_forced(input int k);
    fpf_forced = (k == 0) ? 13'd1 : fpf_free(k - 1);
  endfunction

  // Words skipped by placing a 1 instead of a 0 at unconstrained position j (0 = MSB).
  function automatic logic [12:0] fpf_zero_cnt(input int j, input logic last);
    fpf_zero_cnt = (j == 0 || !last) ? fpf_free(16 - j) : fpf_forced(16 - j);
  endfunction
endpackage

// nbcac_12di_encoder_core: maps a 12-bit word to its 17-bit forbidden-pattern-free codeword.
// Latency: combinational.
// Backpressure: none.
module nbcac_12di_encoder_core (
  input  logic [11:0] din_i,
  output logic [17:1] code_o
);
  import nbcac_fpf_pkg::*;

  logic [12:0] rem;
  logic [12:0] c0;
  logic        last, prev, bit_v;

  // Greedy unranking from the MSB: emit 0 while the remaining index fits in the 0-branch.
  always_comb begin
    rem    = {1'b0, din_i};
    code_o = '0;
    c0     = '0;
    last   = 1'b0;
    prev   = 1'b0;
    bit_v  = 1'b0;
    for (int j = 0; j < 17; j++) begin
      if (j >= 2 && last != prev) begin
        bit_v = last;  // a flip must be followed by a repeat
      end else begin
        c0 = fpf_zero_cnt(j, last);
        if (rem < c0) begin
          bit_v = 1'b0;
        end else begin
          bit_v = 1'b1;
          rem   = rem - c0;
        end
      end
      code_o[17-j] = bit_v;
      prev = last;
      last = bit_v;
    end
  end
endmodule

`ifdef NBCAC_LOOPBACK_CHECK_EN
// nbcac_12di_decoder_core: ranks a 17-bit codeword back to its 12-bit word; flags illegal words.
// Latency: combinational.
// Backpressure: none.
module nbcac_12di_decoder_core (
  input  logic [17:1] code_i,
  output logic [11:0] data_o,
  output logic        illegal_o
);
  import nbcac_fpf_pkg::*;

  logic [12:0] rank;
  logic        last, prev, bit_v, bad;

  always_comb begin
    rank  = '0;
    bad   = 1'b0;
    last  = 1'b0;
    prev  = 1'b0;
    bit_v = 1'b0;
    for (int j = 0; j < 17; j++) begin
      bit_v = code_i[17-j];
      if (j >= 2 && last != prev) begin
        if (bit_v != last) bad = 1'b1;
      end else if (bit_v) begin
        rank = rank + fpf_zero_cnt(j, last);
      end
      prev = last;
      last = bit_v;
    end
    data_o    = rank[11:0];
    illegal_o = bad | rank[12];  // ranks above 4095 are legal patterns no data word produces
  end
endmodule
`endif

module nbcac_tx_stream_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [11:0]      din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic [17:1]      codeout,
  output logic             code_valid,
  input  logic             code_ready,
  output logic [CNT_W-1:0] words_sent,
  output logic             chk_err
);
  localparam int              PTR_W   = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]  DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

  logic [11:0]      mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [17:1]      codeout_q, codeout_d;
  logic             code_valid_q, code_valid_d;
  logic [CNT_W-1:0] words_sent_q, words_sent_d;
  logic [11:0]      head;
  logic [17:1]      enc_word;
  logic             push, pop;

  assign din_ready  = (count_q != DEPTH_C);
  assign codeout    = codeout_q;
  assign code_valid = code_valid_q;
  assign words_sent = words_sent_q;
  assign head       = mem_q[rd_ptr_q];

  nbcac_12di_encoder_core u_enc (.din_i(head), .code_o(enc_word));

  always_comb begin
    push         = din_valid && din_ready;
    pop          = (count_q != '0) && (!code_valid_q || code_ready);
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d      = count_q;
    if (push && !pop)      count_d = count_q + (PTR_W+1)'(1);
    else if (!push && pop) count_d = count_q - (PTR_W+1)'(1);
    // Without a pop the bus keeps its last codeword; only the valid flag drops once consumed.
    codeout_d    = pop ? enc_word : codeout_q;
    code_valid_d = pop ? 1'b1 : (code_valid_q && !code_ready);
    words_sent_d = (code_valid_q && code_ready) ? words_sent_q + CNT_W'(1) : words_sent_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      codeout_q    <= '0;
      code_valid_q <= 1'b0;
      words_sent_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      codeout_q    <= codeout_d;
      code_valid_q <= code_valid_d;
      words_sent_q <= words_sent_d;
    end
  end

  // Storage needs no reset: count/pointers decide what is valid.
  always_ff @(posedge clock) begin
    if (push) mem_q[wr_ptr_q] <= din;
  end

`ifdef NBCAC_LOOPBACK_CHECK_EN
  logic [11:0] shadow_q;
  logic [11:0] lb_data;
  logic        lb_illegal;
  logic        chk_err_q;

  // Decodes the bus-side value so an override on codeout is seen by the checker.
  nbcac_12di_decoder_core u_dec (.code_i(codeout), .data_o(lb_data), .illegal_o(lb_illegal));

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      chk_err_q <= 1'b0;
    end else begin
      if (pop) shadow_q <= head;
      if (code_valid_q && (lb_illegal || lb_data != shadow_q)) chk_err_q <= 1'b1;
    end
  end

  assign chk_err = chk_err_q;
`else
  assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_nbcac_tx_stream_encoder.sv
module tb_nbcac_tx_stream_encoder;
`ifdef NBCAC_LOOPBACK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        rst_n = 1'b1;
  logic [11:0] din = '0;
  logic        din_valid = 1'b0;
  logic        code_ready = 1'b0;

  logic        din_ready, code_valid, chk_err;
  logic [17:1] codeout;
  logic [15:0] words_sent;
  logic        din_ready_w, code_valid_w, chk_err_w;
  logic [17:1] codeout_w;
  logic [3:0]  words_sent_w;

  int checks = 0;
  int failures = 0;

  logic [16:0] enc_tab [4096];
  logic [16:0] exp_q [$];

  typedef struct {
    logic [11:0] din;
    logic        vld;
    logic        rdy;
    logic        exp_cv;
    logic [11:0] exp_word;
    logic        exp_drdy;
    int          exp_ws;
  } vec_t;
  vec_t vecs [14];

  nbcac_tx_stream_encoder #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clock(clock), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .codeout(codeout), .code_valid(code_valid), .code_ready(code_ready),
    .words_sent(words_sent), .chk_err(chk_err));

  nbcac_tx_stream_encoder #(.FIFO_DEPTH(4), .CNT_W(4)) dut_w (
    .clock(clock), .rst_n(rst_n), .din(din), .din_valid(din_valid), .din_ready(din_ready_w),
    .codeout(codeout_w), .code_valid(code_valid_w), .code_ready(code_ready),
    .words_sent(words_sent_w), .chk_err(chk_err_w));

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference code: no 010/101 triple anywhere in the 17-bit word.
  function automatic logic fpf_ok(input logic [16:0] w);
    fpf_ok = 1'b1;
    for (int i = 0; i < 15; i++)
      if (w[i+1] != w[i] && w[i+1] != w[i+2]) fpf_ok = 1'b0;
  endfunction

  // Scoreboard: inputs are stable between the negedge and the next capturing posedge.
  always @(negedge clock) begin
    logic [16:0] w;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (code_valid && code_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", {15'd0, codeout}, 32'h1ffff + 32'd1);
        end else begin
          w = exp_q.pop_front();
          check("sb_codeout", {15'd0, codeout}, {15'd0, w});
        end
      end
      if (din_valid && din_ready) exp_q.push_back(enc_tab[din]);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    din_valid = 1'b0;
    code_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
  endtask

  task automatic stream(input int n, output int cyc);
    logic ok;
    int waited;
    cyc = 0;
    code_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      din = i[11:0];
      din_valid = 1'b1;
      waited = 0;
      do begin
        @(negedge clock);
        ok = din_ready;
        @(posedge clock);
        #1;
        cyc++;
        waited++;
      end while (!ok && waited < 50);
      if (!ok) begin
        check("stream_din_ready", {31'd0, ok}, 32'd1);
        break;
      end
    end
    din_valid = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    int n, cyc;
    n = 0;
    for (int v = 0; v < 131072 && n < 4096; v++) begin
      if (fpf_ok(17'(v))) begin
        enc_tab[n] = 17'(v);
        n++;
      end
    end

    //             din      vld   rdy   cv    word     drdy  ws
    vecs[0]  = '{12'h000, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1, 0};
    vecs[1]  = '{12'h000, 1'b0, 1'b1, 1'b1, 12'h000, 1'b1, 0};
    vecs[2]  = '{12'h000, 1'b0, 1'b1, 1'b0, 12'h000, 1'b1, 1};
    vecs[3]  = '{12'h001, 1'b1, 1'b0, 1'b0, 12'h000, 1'b1, 1};
    vecs[4]  = '{12'h002, 1'b1, 1'b0, 1'b1, 12'h001, 1'b1, 1};
    vecs[5]  = '{12'h003, 1'b1, 1'b0, 1'b1, 12'h001, 1'b1, 1};
    vecs[6]  = '{12'h004, 1'b1, 1'b0, 1'b1, 12'h001, 1'b1, 1};
    vecs[7]  = '{12'h005, 1'b1, 1'b0, 1'b1, 12'h001, 1'b0, 1};
    vecs[8]  = '{12'h005, 1'b0, 1'b0, 1'b1, 12'h001, 1'b0, 1};
    vecs[9]  = '{12'h000, 1'b0, 1'b1, 1'b1, 12'h002, 1'b1, 2};
    vecs[10] = '{12'h000, 1'b0, 1'b1, 1'b1, 12'h003, 1'b1, 3};
    vecs[11] = '{12'h000, 1'b0, 1'b1, 1'b1, 12'h004, 1'b1, 4};
    vecs[12] = '{12'h000, 1'b0, 1'b1, 1'b1, 12'h005, 1'b1, 5};
    vecs[13] = '{12'h000, 1'b0, 1'b1, 1'b0, 12'h005, 1'b1, 6};

    // Reset state
    #1;
    do_reset();
    check("rst_codeout", {15'd0, codeout}, 32'd0);
    check("rst_code_valid", {31'd0, code_valid}, 32'd0);
    check("rst_words_sent", {16'd0, words_sent}, 32'd0);
    check("rst_din_ready", {31'd0, din_ready}, 32'd1);
    check("rst_chk_err", {31'd0, chk_err}, 32'd0);

    // Single word, then stall-and-fill and drain
    for (int i = 0; i < 14; i++) begin
      din = vecs[i].din;
      din_valid = vecs[i].vld;
      code_ready = vecs[i].rdy;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d_code_valid", i), {31'd0, code_valid}, {31'd0, vecs[i].exp_cv});
      check($sformatf("vec%0d_codeout", i), {15'd0, codeout}, {15'd0, enc_tab[vecs[i].exp_word]});
      check($sformatf("vec%0d_din_ready", i), {31'd0, din_ready}, {31'd0, vecs[i].exp_drdy});
      check($sformatf("vec%0d_words_sent", i), {16'd0, words_sent}, vecs[i].exp_ws);
    end
    din_valid = 1'b0;

    // Streaming 4096 words back to back
    stream(4096, cyc);
    check("stream_cycles", cyc, 32'd4096);
    check("stream_ws_inflight", {16'd0, words_sent}, 32'd6 + 32'd4094);
    check("stream_cv_inflight", {31'd0, code_valid}, 32'd1);
    repeat (2) begin @(posedge clock); #1; end
    check("stream_words_sent", {16'd0, words_sent}, 32'd6 + 32'd4096);
    check("stream_cv_idle", {31'd0, code_valid}, 32'd0);
    check("stream_codeout_hold", {15'd0, codeout}, {15'd0, enc_tab[4095]});
    check("stream_w_words_sent", {28'd0, words_sent_w}, (32'd6 + 32'd4096) % 32'd16);
    check("stream_sb_empty", exp_q.size(), 32'd0);
    check("stream_chk_err", {31'd0, chk_err}, 32'd0);

    // Reset with a word on the bus and three buffered
    code_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      din = 12'(256 + i);
      din_valid = 1'b1;
      @(posedge clock);
      #1;
    end
    din_valid = 1'b0;
    check("prerst_code_valid", {31'd0, code_valid}, 32'd1);
    check("prerst_codeout", {15'd0, codeout}, {15'd0, enc_tab[256]});
    #2 rst_n = 1'b0;
    #1;
    check("midrst_codeout", {15'd0, codeout}, 32'd0);
    check("midrst_code_valid", {31'd0, code_valid}, 32'd0);
    check("midrst_words_sent", {16'd0, words_sent}, 32'd0);
    check("midrst_din_ready", {31'd0, din_ready}, 32'd1);
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    code_ready = 1'b1;
    repeat (5) begin @(posedge clock); #1; end
    check("postrst_code_valid", {31'd0, code_valid}, 32'd0);
    check("postrst_words_sent", {16'd0, words_sent}, 32'd0);
    check("postrst_codeout", {15'd0, codeout}, 32'd0);

    // Counter wrap: 17 words into the CNT_W=4 instance
    do_reset();
    stream(17, cyc);
    check("wrap_cycles", cyc, 32'd17);
    repeat (2) begin @(posedge clock); #1; end
    check("wrap_words_sent_16", {16'd0, words_sent}, 32'd17);
    check("wrap_words_sent_4", {28'd0, words_sent_w}, 32'd1);

    // Loopback: corrupt one bus bit while a word is held
    do_reset();
    din = 12'h0A5;
    din_valid = 1'b1;
    @(posedge clock);
    #1 din_valid = 1'b0;
    @(posedge clock);
    #1;
    check("lb_code_valid", {31'd0, code_valid}, 32'd1);
    check("lb_codeout", {15'd0, codeout}, {15'd0, enc_tab[12'h0A5]});
    check("lb_chk_err_clean", {31'd0, chk_err}, 32'd0);
    force dut.codeout = enc_tab[12'h0A5] ^ 17'h00010;
    @(posedge clock);
    #1 release dut.codeout;
    check("lb_chk_err_set", {31'd0, chk_err}, {31'd0, EXP_ERR});
    check("lb_chk_err_other", {31'd0, chk_err_w}, 32'd0);
    repeat (3) begin @(posedge clock); #1; end
    check("lb_chk_err_sticky", {31'd0, chk_err}, {31'd0, EXP_ERR});
    do_reset();
    check("lb_chk_err_reset", {31'd0, chk_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
